// File: rtl/uart_byte_send.sv
`default_nettype none
// ============================================================================
// Module   : uart_byte_send
// Brief    : 8-bit UART transmitter, optional parity, 1 or 2 stop bits.
// Revision : 1.0 - initial release
// ============================================================================
module uart_byte_send #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int UART_BPS  = 115200,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       uart_en,
  input  logic [7:0] uart_din,
  output logic       uart_tx_busy,
  output logic       uart_txd,
  output logic       tx_done
);

  localparam int c_bps_cnt = CLK_FREQ / UART_BPS;
  localparam int c_cnt_w   = (c_bps_cnt > 2) ? $clog2(c_bps_cnt) : 1;

  localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(c_bps_cnt - 1);
  localparam logic [2:0]         c_stop_last = 3'(STOP_BITS - 1);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_start = 3'd1;
  localparam logic [2:0] c_st_data  = 3'd2;
  localparam logic [2:0] c_st_par   = 3'd3;
  localparam logic [2:0] c_st_stop  = 3'd4;

  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_byte_send: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_byte_send: STOP_BITS must be 1 or 2");
  end

  logic                r_en_d0;
  logic                r_en_d1;
  logic                w_start_flag;
  logic [2:0]          r_state;
  logic [2:0]          w_state_nxt;
  logic [c_cnt_w-1:0]  r_clk_cnt;
  logic [c_cnt_w-1:0]  w_clk_cnt_nxt;
  logic [2:0]          r_bit_cnt;
  logic [2:0]          w_bit_cnt_nxt;
  logic [7:0]          r_data;
  logic [7:0]          w_data_nxt;
  logic                w_bit_end;
  logic                w_parity;
  logic                r_txd;
  logic                w_txd_nxt;
  logic                r_busy;
  logic                w_busy_nxt;
  logic                r_done;
  logic                w_done_nxt;

  assign w_start_flag = r_en_d0 & ~r_en_d1;
  assign w_bit_end    = (r_clk_cnt == c_cnt_last);
  // Even parity makes the total count of ones even; odd parity inverts it.
  assign w_parity     = (PARITY == 2) ? (^r_data) : ~(^r_data);

  // State register
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_start_flag) w_state_nxt = c_st_start;
      end
      c_st_start: begin
        if (w_bit_end) w_state_nxt = c_st_data;
      end
      c_st_data: begin
        if (w_bit_end && r_bit_cnt == 3'd7)
          w_state_nxt = (PARITY != 0) ? c_st_par : c_st_stop;
      end
      c_st_par: begin
        if (w_bit_end) w_state_nxt = c_st_stop;
      end
      c_st_stop: begin
        if (w_bit_end && r_bit_cnt == c_stop_last) w_state_nxt = c_st_idle;
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  // Bit timing and data capture; bit_cnt restarts whenever the state changes.
  always_comb begin
    w_clk_cnt_nxt = r_clk_cnt + c_cnt_w'(1);
    if (r_state == c_st_idle || w_bit_end) w_clk_cnt_nxt = '0;

    w_bit_cnt_nxt = r_bit_cnt;
    if (w_state_nxt != r_state) w_bit_cnt_nxt = 3'd0;
    else if (w_bit_end)         w_bit_cnt_nxt = r_bit_cnt + 3'd1;

    w_data_nxt = r_data;
    if (r_state == c_st_idle && w_start_flag) w_data_nxt = uart_din;
  end

  // Output logic: computed from the next state so outputs leave a flop.
  always_comb begin
    w_busy_nxt = (w_state_nxt != c_st_idle);
    w_done_nxt = (r_state == c_st_stop) && (w_state_nxt == c_st_idle);
    w_txd_nxt  = 1'b1;
    case (w_state_nxt)
      c_st_start: w_txd_nxt = 1'b0;
      c_st_data:  w_txd_nxt = r_data[w_bit_cnt_nxt];
      c_st_par:   w_txd_nxt = w_parity;
      default:    w_txd_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_en_d0   <= 1'b0;
      r_en_d1   <= 1'b0;
      r_clk_cnt <= '0;
      r_bit_cnt <= 3'd0;
      r_data    <= 8'd0;
      r_txd     <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_en_d0   <= uart_en;
      r_en_d1   <= r_en_d0;
      r_clk_cnt <= w_clk_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_data    <= w_data_nxt;
      r_txd     <= w_txd_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  assign uart_txd     = r_txd;
  assign uart_tx_busy = r_busy;
  assign tx_done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_byte_send.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_byte_send
// Brief    : Self-checking bench for uart_byte_send (four configurations).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_byte_send;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       uart_en  [4];
  logic [7:0] uart_din [4];
  wire        txd  [4];
  wire        busy [4];
  wire        done [4];

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  uart_byte_send #(.CLK_FREQ(50_000_000), .UART_BPS(115200), .PARITY(0), .STOP_BITS(1)) u_dut0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_en(uart_en[0]), .uart_din(uart_din[0]),
    .uart_tx_busy(busy[0]), .uart_txd(txd[0]), .tx_done(done[0]));
  uart_byte_send #(.CLK_FREQ(50_000_000), .UART_BPS(115200), .PARITY(2), .STOP_BITS(1)) u_dut1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_en(uart_en[1]), .uart_din(uart_din[1]),
    .uart_tx_busy(busy[1]), .uart_txd(txd[1]), .tx_done(done[1]));
  uart_byte_send #(.CLK_FREQ(50_000_000), .UART_BPS(115200), .PARITY(0), .STOP_BITS(2)) u_dut2 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_en(uart_en[2]), .uart_din(uart_din[2]),
    .uart_tx_busy(busy[2]), .uart_txd(txd[2]), .tx_done(done[2]));
  uart_byte_send #(.CLK_FREQ(1_600_000), .UART_BPS(100_000), .PARITY(1), .STOP_BITS(2)) u_dut3 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .uart_en(uart_en[3]), .uart_din(uart_din[3]),
    .uart_tx_busy(busy[3]), .uart_txd(txd[3]), .tx_done(done[3]));

  function automatic int bps_of(input int k);
    return (k == 3) ? 16 : 434;
  endfunction
  function automatic int par_of(input int k);
    case (k)
      1:       return 2;
      3:       return 1;
      default: return 0;
    endcase
  endfunction
  function automatic int stop_of(input int k);
    return (k >= 2) ? 2 : 1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Sends one byte on instance k and checks the whole line waveform.
  // chained: request already raised by the previous frame's last cycle.
  // glitch: raise a second request with 0x55 in mid-frame.
  // abort_at: sample index at which to pulse reset (-1 for none).
  task automatic do_frame(input int k, input logic [7:0] b, input bit chained, input int hold,
                          input bit glitch, input int abort_at,
                          input bit chain_next, input logic [7:0] next_b);
    bit q[$];
    int bps, n, total, ok, busy_cnt, done_cnt, idx, glitch_at;
    bps = bps_of(k);
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(b[i]);
    if (par_of(k) != 0) begin
      if (par_of(k) == 2) q.push_back(($countones(b) % 2) == 1);
      else                q.push_back(($countones(b) % 2) == 0);
    end
    for (int s = 0; s < stop_of(k); s++) q.push_back(1'b1);
    n = q.size();
    total = n * bps;
    glitch_at = glitch ? total / 2 : -1;

    if (!chained) begin
      uart_din[k] = b;
      uart_en[k]  = 1'b1;
      @(negedge sys_clk);
      check_eq("pre_txd", txd[k], 1);
      check_eq("pre_busy", busy[k], 0);
    end
    @(negedge sys_clk);

    busy_cnt = 0;
    done_cnt = 0;
    for (int i = 0; i < n; i++) begin
      ok = 0;
      for (int c = 0; c < bps; c++) begin
        idx = i * bps + c;
        if (idx == abort_at) begin
          sys_rst_n  = 1'b0;
          uart_en[k] = 1'b0;
          @(negedge sys_clk);
          check_eq("abort_txd", txd[k], 1);
          check_eq("abort_busy", busy[k], 0);
          check_eq("abort_done", done[k], 0);
          sys_rst_n = 1'b1;
          done_cnt = 0;
          for (int w = 0; w < 2 * bps; w++) begin
            @(negedge sys_clk);
            if (done[k] === 1'b1 || busy[k] === 1'b1) done_cnt++;
          end
          check_eq("abort_quiet", done_cnt, 0);
          return;
        end
        if (txd[k] === q[i])     ok++;
        if (busy[k] === 1'b1)    busy_cnt++;
        if (done[k] === 1'b1)    done_cnt++;
        if (idx == hold - 2) begin
          uart_en[k]  = 1'b0;
          uart_din[k] = 8'($urandom);
        end
        if (idx == glitch_at)     begin uart_en[k] = 1'b1; uart_din[k] = 8'h55; end
        if (idx == glitch_at + 3) uart_en[k] = 1'b0;
        if (chain_next && idx == total - 1) begin
          uart_en[k]  = 1'b1;
          uart_din[k] = next_b;
        end
        @(negedge sys_clk);
      end
      check_eq($sformatf("dut%0d_bit%0d", k, i), ok, bps);
    end
    check_eq("busy_cycles", busy_cnt, total);
    check_eq("done_in_frame", done_cnt, 0);
    check_eq("end_busy", busy[k], 0);
    check_eq("end_done", done[k], 1);
    check_eq("end_txd", txd[k], 1);
    if (!chain_next) begin
      uart_en[k] = 1'b0;
      busy_cnt = 0;
      done_cnt = 0;
      for (int w = 0; w < 6; w++) begin
        @(negedge sys_clk);
        if (busy[k] === 1'b1 || txd[k] !== 1'b1) busy_cnt++;
        if (done[k] === 1'b1) done_cnt++;
      end
      check_eq("idle_after", busy_cnt, 0);
      check_eq("done_width", done_cnt, 0);
    end
  endtask

  initial begin
    repeat (200000) @(posedge sys_clk);
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b, nb;
    bit pend, cn;
    sys_rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      uart_en[k]  = 1'b0;
      uart_din[k] = 8'h00;
    end
    repeat (3) @(negedge sys_clk);
    for (int k = 0; k < 4; k++) begin
      check_eq("rst_txd", txd[k], 1);
      check_eq("rst_busy", busy[k], 0);
      check_eq("rst_done", done[k], 0);
    end

    // Request held high across reset release is still honoured.
    uart_en[0]  = 1'b1;
    uart_din[0] = 8'hAF;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    do_frame(0, 8'hAF, 1'b0, 3, 1'b0, -1, 1'b0, 8'h00);

    do_frame(1, 8'h07, 1'b0, 3, 1'b0, -1, 1'b0, 8'h00);
    do_frame(2, 8'hFA, 1'b0, 3, 1'b0, -1, 1'b0, 8'h00);
    do_frame(3, 8'h07, 1'b0, 3, 1'b0, -1, 1'b0, 8'h00);

    do_frame(0, 8'hAF, 1'b0, 3, 1'b1, -1, 1'b0, 8'h00);

    do_frame(0, 8'hAF, 1'b0, 3, 1'b0, -1, 1'b1, 8'hFA);
    do_frame(0, 8'hFA, 1'b1, 3, 1'b0, -1, 1'b1, 8'h55);
    do_frame(0, 8'h55, 1'b1, 3, 1'b0, -1, 1'b0, 8'h00);

    do_frame(0, 8'hC3, 1'b0, 3, 1'b0, 4 * 434 + 217, 1'b0, 8'h00);
    do_frame(0, 8'h3C, 1'b0, 3, 1'b0, -1, 1'b0, 8'h00);

    pend = 1'b0;
    nb   = 8'h00;
    for (int r = 0; r < 20; r++) begin
      b  = pend ? nb : 8'($urandom);
      cn = (r < 19) && ($urandom_range(1, 0) == 1);
      nb = 8'($urandom);
      do_frame(3, b, pend, int'($urandom_range(6, 2)), $urandom_range(1, 0) == 1, -1, cn, nb);
      pend = cn;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
